// File: rtl/mem_access_unit.sv
// Memory stage: one load/store per handshake onto a word-addressed data bus.
// Returns aligned, extended load data or a fault to writeback/hazard logic.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TMO_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  mem_op,
   input  logic [2:0]  mem_sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   localparam logic [2:0] SEL_BS  = 3'd0;
   localparam logic [2:0] SEL_BU  = 3'd1;
   localparam logic [2:0] SEL_HS  = 3'd2;
   localparam logic [2:0] SEL_HU  = 3'd3;
   localparam logic [2:0] SEL_W   = 3'd4;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [2:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;

   logic        in_byte, in_half, in_word, in_uns;
   logic        in_bad, in_misal;
   logic [31:0] lane;
   logic [31:0] ld_ext;
   logic [3:0]  be;
   logic [31:0] st_data;
   logic        is_store;
   logic        on_bus;

   always_comb begin
      in_byte  = (mem_sel == SEL_BS) || (mem_sel == SEL_BU);
      in_half  = (mem_sel == SEL_HS) || (mem_sel == SEL_HU);
      in_word  = (mem_sel == SEL_W);
      in_uns   = (mem_sel == SEL_BU) || (mem_sel == SEL_HU);
      // op 2'b11 is undefined and is reported as a fault
      in_bad   = (mem_op == 2'd3)
               || !(in_byte || in_half || in_word)
               || ((mem_op == OP_STORE) && in_uns);
      in_misal = (in_half && addr[0]) || (in_word && (addr[1:0] != 2'b00));
   end

   always_comb begin
      lane   = dmem_rdata >> {addr_q[1:0], 3'b000};
      ld_ext = lane;
      unique case (sel_q)
         SEL_BS:  ld_ext = {{24{lane[7]}}, lane[7:0]};
         SEL_BU:  ld_ext = {24'b0, lane[7:0]};
         SEL_HS:  ld_ext = {{16{lane[15]}}, lane[15:0]};
         SEL_HU:  ld_ext = {16'b0, lane[15:0]};
         default: ld_ext = lane;
      endcase
   end

   always_comb begin
      be      = 4'b0000;
      st_data = 32'b0;
      unique case (sel_q)
         SEL_BS, SEL_BU: begin
            be      = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         SEL_HS, SEL_HU: begin
            be      = 4'b0011 << {addr_q[1], 1'b0};
            st_data = {2{wdata_q[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            st_data = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = mem_op;
               sel_d   = mem_sel;
               addr_d  = addr;
               wdata_d = wdata;
               rd_d    = rd_in;
               rdata_d = 32'b0;
               cnt_d   = '0;
               err_d   = 1'b0;
               if (mem_op == OP_NOP) begin
                  state_d = RESP;
               end else if (in_bad || in_misal) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            // ack on the timeout cycle still completes normally
            if (dmem_ack) begin
               rdata_d = (op_q == OP_LOAD) ? ld_ext : 32'b0;
               state_d = RESP;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         sel_q   <= 3'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         rd_q    <= 5'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign is_store   = (op_q == OP_STORE);
   assign on_bus     = (state_q == BUS);
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = resp_valid ? rdata_q : 32'b0;
   assign resp_rd    = resp_valid ? rd_q : 5'b0;
   assign dmem_req   = on_bus;
   assign dmem_we    = on_bus & is_store;
   assign dmem_addr  = on_bus ? {addr_q[31:2], 2'b00} : 32'b0;
   assign dmem_be    = on_bus ? be : 4'b0000;
   assign dmem_wdata = (on_bus && is_store) ? st_data : 32'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors, bus responder,
// response monitor popping expected results from a queue.
module tb_mem_access_unit;

   localparam logic [1:0] OP_NOP = 2'd0, OP_LD = 2'd1, OP_ST = 2'd2;
   localparam logic [2:0] BS = 3'd0, BU = 3'd1, HS = 3'd2, HU = 3'd3;
   localparam logic [2:0] W = 3'd4, SNOP = 3'd5, S7 = 3'd7;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  mem_op;
   logic [2:0]  mem_sel;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_in;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   mem_access_unit #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .mem_op(mem_op), .mem_sel(mem_sel),
      .addr(addr), .wdata(wdata), .rd_in(rd_in),
      .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .resp_rd(resp_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          lat;
      int          acc;
   } rexp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   int    compared = 0;
   int    mismatched = 0;
   int    cyc = 0;
   bit    busy = 0;
   bit    late_ack = 0;
   int    bcnt = 0;
   int    last_req_len = 0;
   bexp_t cur;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // response monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
         if (resp_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
               rexp_t e;
               e = rq.pop_front();
               chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
               chk("resp_latency", cyc - e.acc, e.lat);
            end
            busy = 0;
         end else begin
            chk("idle_resp_zero",
                {resp_rdata[31:6], resp_err, resp_rd}, 32'd0);
         end
      end
   end

   // bus responder
   always @(negedge clk) begin
      if (dmem_req) begin
         if (bcnt == 0) begin
            if (bq.size() == 0) begin
               chk("unexpected_dmem_req", 32'd1, 32'd0);
               cur = '{1'b0, 32'b0, 4'b0, 32'b0, -1, 32'b0};
            end else begin
               cur = bq.pop_front();
            end
         end
         chk("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
         chk("dmem_addr", dmem_addr, cur.addr);
         chk("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
         if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
         dmem_ack   = (cur.delay >= 0) && (bcnt == cur.delay);
         dmem_rdata = dmem_ack ? cur.rdata : 32'h5A5A5A5A;
         bcnt++;
      end else begin
         if (bcnt != 0) last_req_len = bcnt;
         bcnt       = 0;
         dmem_ack   = late_ack;
         dmem_rdata = 32'h5A5A5A5A;
      end
   end

   task automatic bus_exp(logic we, logic [31:0] a, logic [3:0] b,
                          logic [31:0] wd, int dly, logic [31:0] rdv);
      bexp_t x;
      x = '{we, a, b, wd, dly, rdv};
      bq.push_back(x);
   endtask

   // chain=1: called #1 after the previous accept edge with req_valid held
   task automatic issue(logic [1:0] op, logic [2:0] sel, logic [31:0] a,
                        logic [31:0] wd, logic [4:0] rd, logic err,
                        logic [31:0] rdv, int lat, bit chain, bit hold);
      rexp_t e;
      int n;
      if (!chain) begin
         @(posedge clk);
         #1;
      end
      req_valid = 1'b1;
      mem_op    = op;
      mem_sel   = sel;
      addr      = a;
      wdata     = wd;
      rd_in     = rd;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      e = '{err, rdv, rd, lat, cyc};
      rq.push_back(e);
      @(posedge clk);
      busy = 1;
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && rq.size() != 0; i++) @(negedge clk);
      if (rq.size() != 0) begin
         chk("drain_timeout", rq.size(), 32'd0);
         rq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      mem_op     = OP_NOP;
      mem_sel    = SNOP;
      addr       = 32'b0;
      wdata      = 32'b0;
      rd_in      = 5'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'b0;
      #12;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_outputs",
          {dmem_req, dmem_we, resp_valid, resp_err, dmem_be,
           dmem_addr[23:0]}, 32'd0);
      chk("rst_data", resp_rdata | dmem_wdata | {27'b0, resp_rd}, 32'd0);
      #10;
      rst_n = 1'b1;

      // SB lane 3
      bus_exp(1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 32'h0);
      issue(OP_ST, BS, 32'h1003, 32'h000000A5, 5'd1, 0, 32'h0, 2, 0, 0);
      drain();
      // LB / LBU lane 1
      bus_exp(0, 32'h2000, 4'b0010, 32'h0, 0, 32'h00008000);
      issue(OP_LD, BS, 32'h2001, 32'h0, 5'd2, 0, 32'hFFFFFF80, 2, 0, 0);
      drain();
      bus_exp(0, 32'h2000, 4'b0010, 32'h0, 0, 32'h00008000);
      issue(OP_LD, BU, 32'h2001, 32'h0, 5'd3, 0, 32'h00000080, 2, 0, 0);
      drain();
      // LH upper half, misaligned SW
      bus_exp(0, 32'h2000, 4'b1100, 32'h0, 0, 32'h12345678);
      issue(OP_LD, HS, 32'h2002, 32'h0, 5'd4, 0, 32'h00001234, 2, 0, 0);
      drain();
      issue(OP_ST, W, 32'h3002, 32'hFFFFFFFF, 5'd5, 1, 32'h0, 1, 0, 0);
      drain();
      // more extension and lane cases
      bus_exp(0, 32'h0010, 4'b0011, 32'h0, 0, 32'h0000F00F);
      issue(OP_LD, HS, 32'h0010, 32'h0, 5'd6, 0, 32'hFFFFF00F, 2, 0, 0);
      drain();
      bus_exp(0, 32'h0010, 4'b1100, 32'h0, 0, 32'h80010000);
      issue(OP_LD, HU, 32'h0012, 32'h0, 5'd7, 0, 32'h00008001, 2, 0, 0);
      drain();
      bus_exp(0, 32'h0020, 4'b1111, 32'h0, 2, 32'hDEADBEEF);
      issue(OP_LD, W, 32'h0020, 32'h0, 5'd8, 0, 32'hDEADBEEF, 4, 0, 0);
      drain();
      bus_exp(0, 32'h0020, 4'b1000, 32'h0, 0, 32'h7F000000);
      issue(OP_LD, BS, 32'h0023, 32'h0, 5'd13, 0, 32'h0000007F, 2, 0, 0);
      drain();
      bus_exp(1, 32'h8000, 4'b1111, 32'h12345678, 0, 32'h0);
      issue(OP_ST, W, 32'h8000, 32'h12345678, 5'd20, 0, 32'h0, 2, 0, 0);
      drain();
      // fault decode, no bus traffic
      issue(OP_ST, BU, 32'h0000, 32'h11, 5'd14, 1, 32'h0, 1, 0, 0);
      drain();
      issue(OP_LD, HS, 32'h1001, 32'h0, 5'd15, 1, 32'h0, 1, 0, 0);
      drain();
      issue(OP_LD, SNOP, 32'h0000, 32'h0, 5'd16, 1, 32'h0, 1, 0, 0);
      drain();
      issue(OP_LD, S7, 32'h0000, 32'h0, 5'd17, 1, 32'h0, 1, 0, 0);
      drain();
      issue(OP_ST, W, 32'h3001, 32'h0, 5'd21, 1, 32'h0, 1, 0, 0);
      drain();
      issue(OP_NOP, W, 32'h0003, 32'h0, 5'd18, 0, 32'h0, 1, 0, 0);
      drain();
      // ack on the last allowed cycle completes normally
      bus_exp(0, 32'h9000, 4'b1111, 32'h0, 3, 32'h0BADF00D);
      issue(OP_LD, W, 32'h9000, 32'h0, 5'd19, 0, 32'h0BADF00D, 5, 0, 0);
      drain();
      chk("req_len_ack_last", last_req_len, 32'd4);
      // timeout, then a stray ack is ignored
      bus_exp(0, 32'h4000, 4'b1111, 32'h0, -1, 32'h0);
      issue(OP_LD, W, 32'h4000, 32'h0, 5'd9, 1, 32'h0, 5, 0, 0);
      drain();
      chk("req_len_timeout", last_req_len, 32'd4);
      late_ack = 1;
      repeat (3) @(negedge clk);
      late_ack = 0;
      repeat (2) @(negedge clk);
      chk("late_ack_idle", {31'b0, req_ready}, 32'd1);

      // async reset mid-bus
      bus_exp(0, 32'h7000, 4'b1111, 32'h0, -1, 32'h0);
      issue(OP_LD, W, 32'h7000, 32'h0, 5'd22, 1, 32'h0, 5, 0, 0);
      repeat (2) @(negedge clk);
      chk("pre_rst_dmem_req", {31'b0, dmem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      rq.delete();
      busy = 0;
      #1;
      chk("rst_dmem_req_drop", {31'b0, dmem_req}, 32'd0);
      chk("rst_ready_mid", {31'b0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
      #3;
      rst_n = 1'b1;
      bus_exp(0, 32'h7004, 4'b1111, 32'h0, 1, 32'h11223344);
      issue(OP_LD, W, 32'h7004, 32'h0, 5'd23, 0, 32'h11223344, 3, 0, 0);
      drain();

      // back-to-back with req_valid held
      bus_exp(1, 32'h5000, 4'b1100, 32'hBEEFBEEF, 0, 32'h0);
      bus_exp(0, 32'h6000, 4'b1111, 32'h0, 1, 32'hCAFEF00D);
      issue(OP_NOP, SNOP, 32'h0, 32'h0, 5'd10, 0, 32'h0, 1, 0, 1);
      issue(OP_ST, HS, 32'h5002, 32'h0000BEEF, 5'd11, 0, 32'h0, 2, 1, 1);
      issue(OP_LD, W, 32'h6000, 32'h0, 5'd12, 0, 32'hCAFEF00D, 3, 1, 0);
      drain();
      repeat (3) @(negedge clk);
      chk("bus_queue_empty", bq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
